// File: rtl/usb_link_pkg.sv
// Shared types and widths for the USB link-state controller.
package usb_link_pkg;

   localparam int US_CNT_W   = 13;
   localparam int US_CNT_MAX = (1 << US_CNT_W) - 1;

   typedef enum logic [1:0] {
      LINE_SE0 = 2'd0,
      LINE_J   = 2'd1,
      LINE_K   = 2'd2,
      LINE_SE1 = 2'd3
   } line_state_t;

   // RESUME_DRIVE keeps its encoding even in builds without remote wakeup.
   typedef enum logic [2:0] {
      LINK_ACTIVE       = 3'd0,
      LINK_RESET        = 3'd1,
      LINK_SUSPEND      = 3'd2,
      LINK_RESUME_HOST  = 3'd3,
      LINK_RESUME_DRIVE = 3'd4
   } link_state_t;

   function automatic logic [US_CNT_W-1:0] satInc(input logic [US_CNT_W-1:0] value);
      return (value == US_CNT_W'(US_CNT_MAX)) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/usb_link_ctrl_if.sv
// PHY/SIE-facing signal bundle of the link-state controller.
interface usb_link_ctrl_if;
   import usb_link_pkg::*;

   logic        usb_full_speed;
   line_state_t line_state;
   logic        remote_wakeup_i;
   link_state_t state_o;
   logic        bus_reset_o;
   logic        suspend_o;
   logic        resume_o;
   logic        drive_k_o;

   modport master (
      output usb_full_speed, line_state, remote_wakeup_i,
      input  state_o, bus_reset_o, suspend_o, resume_o, drive_k_o
   );

   modport slave (
      input  usb_full_speed, line_state, remote_wakeup_i,
      output state_o, bus_reset_o, suspend_o, resume_o, drive_k_o
   );

endinterface

// File: rtl/usb_us_tick.sv
// One-clock microsecond tick from the PHY clock; a speed change restarts the divider.
module usb_us_tick #(
   parameter int FS_DIV = 48,
   parameter int LS_DIV = 6
)(
   input  logic clk,
   input  logic reset_ni,
   input  logic usb_full_speed,
   output logic tick
);

   localparam int DIV_MAX = (FS_DIV > LS_DIV) ? FS_DIV : LS_DIV;
   localparam int DIV_W   = $clog2(DIV_MAX + 1);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_last;
   logic             r_speed;
   logic             w_speedChange;

   assign w_last        = usb_full_speed ? DIV_W'(FS_DIV - 1) : DIV_W'(LS_DIV - 1);
   assign w_speedChange = (usb_full_speed != r_speed);
   // The partial period in flight when the speed flips is discarded.
   assign tick          = !w_speedChange && (r_div == w_last);

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_div   <= '0;
         r_speed <= 1'b0;
      end else begin
         r_speed <= usb_full_speed;
         if (w_speedChange || (r_div == w_last)) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_link_ctrl.sv
// USB device link-state controller: bus reset, suspend and resume sequencing from PHY line state.
// Remote-wakeup K drive is built only when USB_REMOTE_WAKEUP_EN is defined.
module usb_link_ctrl
   import usb_link_pkg::*;
#(
   parameter int FS_DIV       = 48,
   parameter int LS_DIV       = 6,
   parameter int RESET_US     = 4,
   parameter int SUSPEND_US   = 3000,
   parameter int WAKE_IDLE_US = 5000,
   parameter int DRIVE_K_US   = 2000
)(
   input logic           clk,
   input logic           reset_ni,
   usb_link_ctrl_if.slave link
);

   if ((RESET_US > US_CNT_MAX) || (SUSPEND_US > US_CNT_MAX) ||
       (WAKE_IDLE_US > US_CNT_MAX) || (DRIVE_K_US > US_CNT_MAX)) begin : g_paramCheck
      $error("usb_link_ctrl: a *_US parameter exceeds the 13-bit timer range");
   end

   localparam logic [US_CNT_W-1:0] C_RESET   = US_CNT_W'(RESET_US);
   localparam logic [US_CNT_W-1:0] C_SUSPEND = US_CNT_W'(SUSPEND_US);
   localparam logic [US_CNT_W-1:0] C_DRIVE_K = US_CNT_W'(DRIVE_K_US);

   link_state_t         r_state;
   link_state_t         w_nextState;
   logic [US_CNT_W-1:0] r_se0Cnt;
   logic [US_CNT_W-1:0] r_idleCnt;
   logic [US_CNT_W-1:0] r_tmr;
   logic                w_tick;
   logic                w_stateChange;
   logic                w_wakeReady;

   usb_us_tick #(
      .FS_DIV (FS_DIV),
      .LS_DIV (LS_DIV)
   ) u_tick (
      .clk            (clk),
      .reset_ni       (reset_ni),
      .usb_full_speed (link.usb_full_speed),
      .tick           (w_tick)
   );

   assign w_stateChange = (w_nextState != r_state);

`ifdef USB_REMOTE_WAKEUP_EN
   localparam logic [US_CNT_W-1:0] C_WAKE_IDLE = US_CNT_W'(WAKE_IDLE_US);

   logic r_wakePending;

   // An early request is remembered until the minimum suspend time has elapsed.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wakePending <= 1'b0;
      end else if ((r_state != LINK_SUSPEND) || w_stateChange) begin
         r_wakePending <= 1'b0;
      end else if (link.remote_wakeup_i) begin
         r_wakePending <= 1'b1;
      end
   end

   assign w_wakeReady    = r_wakePending && (r_tmr >= C_WAKE_IDLE);
   assign link.drive_k_o = (r_state == LINK_RESUME_DRIVE);
`else
   logic w_unused;
   assign w_unused       = link.remote_wakeup_i;
   assign w_wakeReady    = 1'b0;
   assign link.drive_k_o = 1'b0;
`endif

   // Every state change restarts all three timers so each state measures from its own entry.
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_se0Cnt  <= '0;
         r_idleCnt <= '0;
         r_tmr     <= '0;
      end else if (w_stateChange) begin
         r_se0Cnt  <= '0;
         r_idleCnt <= '0;
         r_tmr     <= '0;
      end else begin
         if (link.line_state != LINE_SE0) begin
            r_se0Cnt <= '0;
         end else if (w_tick) begin
            r_se0Cnt <= satInc(r_se0Cnt);
         end
         if (link.line_state != LINE_J) begin
            r_idleCnt <= '0;
         end else if (w_tick) begin
            r_idleCnt <= satInc(r_idleCnt);
         end
         if (w_tick && ((r_state == LINK_SUSPEND) || (r_state == LINK_RESUME_DRIVE))) begin
            r_tmr <= satInc(r_tmr);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= LINK_ACTIVE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         LINK_ACTIVE: begin
            if (r_se0Cnt == C_RESET) begin
               w_nextState = LINK_RESET;
            end else if (r_idleCnt == C_SUSPEND) begin
               w_nextState = LINK_SUSPEND;
            end
         end
         LINK_RESET: begin
            if (link.line_state != LINE_SE0) begin
               w_nextState = LINK_ACTIVE;
            end
         end
         // Bus reset outranks host resume, which outranks our own wakeup.
         LINK_SUSPEND: begin
            if (r_se0Cnt == C_RESET) begin
               w_nextState = LINK_RESET;
            end else if (link.line_state == LINE_K) begin
               w_nextState = LINK_RESUME_HOST;
            end else if (w_wakeReady) begin
               w_nextState = LINK_RESUME_DRIVE;
            end
         end
         LINK_RESUME_HOST: begin
            if (link.line_state != LINE_K) begin
               w_nextState = LINK_ACTIVE;
            end
         end
         LINK_RESUME_DRIVE: begin
            if (r_tmr == C_DRIVE_K) begin
               w_nextState = LINK_RESUME_HOST;
            end
         end
         default: w_nextState = LINK_ACTIVE;
      endcase
   end

   assign link.state_o     = r_state;
   assign link.bus_reset_o = (r_state == LINK_RESET);
   assign link.suspend_o   = (r_state == LINK_SUSPEND);
   assign link.resume_o    = (r_state == LINK_RESUME_HOST) && (link.line_state != LINE_K);

endmodule

// File: doc/usb_link_ctrl.md
Name: usb_link_ctrl

Overview:
- USB device link-state controller. Watches the PHY line state and sequences the bus through ACTIVE, RESET, SUSPEND and RESUME.
- Detects bus reset (SE0 held for at least 2.5 µs), suspend (idle J for 3 ms) and host resume (K).
- Drives the remote-wakeup K when that feature is compiled in.
- Sits between the PHY receiver and the SIE/device-state logic, in the same clock domain as the PHY.

Parameters:
- FS_DIV, 48, clocks per µs at full speed (48 MHz).
- LS_DIV, 6, clocks per µs at low speed (6 MHz).
- RESET_US, 4, µs ticks of continuous SE0 needed to declare bus reset.
- SUSPEND_US, 3000, µs ticks of continuous J needed to declare suspend.
- WAKE_IDLE_US, 5000, minimum µs spent in SUSPEND before remote wakeup is allowed.
- DRIVE_K_US, 2000, µs for which the device drives K during remote wakeup.

Ports:
- clk  input  1  system clock, 6 or 48 MHz.
- reset_ni  input  1  asynchronous, active-low reset.
- usb_full_speed  input  1  0: low-speed, 1: full-speed.
- line_state  input  2  PHY line state, type line_state_t: SE0=0, J=1, K=2, SE1=3.
- remote_wakeup_i  input  1  one-cycle wakeup request from device logic.
- state_o  output  3  current link state, type link_state_t.
- bus_reset_o  output  1  high while in RESET.
- suspend_o  output  1  high while in SUSPEND.
- resume_o  output  1  one-cycle pulse on the RESUME_HOST→ACTIVE transition.
- drive_k_o  output  1  high while the device must drive K.

Behaviour:
- Reset: reset_ni low sets state=ACTIVE, clears all counters and the pending flag, and drives every output to 0. It takes effect asynchronously, including mid-operation, and aborts any K drive immediately.
- Tick generation: sub-module produces a one-clk tick every FS_DIV or LS_DIV clocks. When usb_full_speed changes, the divider reloads to 0 and that one tick period is lost.
- Timer counters: se0_cnt, idle_cnt and tmr, each 13-bit and saturating at 8191 (never wrap).
- Parameter check: elaboration assert that every *_US parameter is ≤ 8191.
- se0_cnt: increments on tick while line_state==SE0; clears in the same cycle line_state≠SE0.
- idle_cnt: increments on tick while line_state==J; clears otherwise. SE1 counts as non-idle and non-SE0.
- ACTIVE:
  - se0_cnt==RESET_US → RESET on the next clk.
  - Else idle_cnt==SUSPEND_US → SUSPEND.
  - Reset detect latency is RESET_US−1 to RESET_US µs after SE0 starts. A normal EOP (≤1.4 µs) never triggers it.
- RESET: bus_reset_o=1. When line_state≠SE0 → ACTIVE. All counters clear on exit.
- SUSPEND:
  - suspend_o=1. tmr counts µs since entry.
  - line_state==K → RESUME_HOST.
  - se0_cnt==RESET_US → RESET.
  - Pending wakeup and tmr≥WAKE_IDLE_US → RESUME_DRIVE.
  - Priority order: RESET, then K, then wakeup.
- RESUME_DRIVE: drive_k_o=1 and tmr restarts at entry. When tmr==DRIVE_K_US, drive_k_o falls and the state becomes RESUME_HOST. Line activity is ignored during the drive.
- RESUME_HOST: remains while line_state==K. Any other line state → ACTIVE, with resume_o pulsing in that same cycle and se0_cnt continuing from 0.
- Pending wakeup flag:
  - Set by remote_wakeup_i only while in SUSPEND.
  - Cleared on any exit from SUSPEND.
  - Ignored in all other states.
  - A request before WAKE_IDLE_US is held until that time.
- state_o / flag timing: state_o is registered. bus_reset_o, suspend_o and drive_k_o are decoded from the registered state.

Optional Feature:
- Macro: USB_REMOTE_WAKEUP_EN.
- Defined: pending flag, RESUME_DRIVE state and drive_k_o behave as above.
- Undefined:
  - remote_wakeup_i is ignored and drive_k_o is tied 0.
  - RESUME_DRIVE is unreachable; its encoding stays reserved in the package.
  - No pending flag is generated.

Decomposition:
- Package usb_link_pkg:
  - line_state_t (2-bit enum SE0/J/K/SE1).
  - link_state_t (3-bit enum ACTIVE=0, RESET=1, SUSPEND=2, RESUME_HOST=3, RESUME_DRIVE=4).
  - Counter-width localparam US_CNT_W=13.
- Sub-module usb_us_tick: clk, reset_ni, usb_full_speed → tick. Divider with reload-on-speed-change.

Test Plan:
- FS, J idle, then SE0 for 5 µs (240 clk) → bus_reset_o rises between 3 and 4 µs after SE0 start. On return to J, state_o=ACTIVE, bus_reset_o=0.
- FS, SE0 for 1.4 µs repeated 1000× between J packets → bus_reset_o never asserts and state stays ACTIVE.
- LS, J for 3001 µs → suspend_o=1 within 3000–3001 µs. Then K for 20 ms, then SE0 → resume_o pulses for exactly 1 clk and state_o=ACTIVE.
- SUSPEND, remote_wakeup_i pulse at 1 ms (with USB_REMOTE_WAKEUP_EN) → drive_k_o asserts at 5 ms, holds for 2000 µs, then state_o=RESUME_HOST.
- SUSPEND, SE0 starts in the same cycle the wakeup threshold is met → RESET wins and drive_k_o stays 0. Without the macro, wakeup pulses never raise drive_k_o.
- reset_ni driven low mid-RESUME_DRIVE (no clk edge) → drive_k_o=0 and state_o=ACTIVE immediately. Also toggle usb_full_speed mid-SUSPEND → the timer loses at most one tick.
